// File: rtl/ds_link_rx.sv
// IEEE 1355 DS-DE link receiver: bit recovery, character decode, parity/disconnect checks, RX FIFO.
// Defining DS_LINK_RX_STATS_EN adds the char_count/err_count statistics outputs.
module ds_link_rx #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 8,
    parameter int DISC_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   d_in,
    input  logic                   s_in,
    input  logic                   rx_ready,
    input  logic                   err_clr,
    output logic                   rx_valid,
    output logic                   rx_ctrl,
    output logic [DATA_W-1:0]      rx_data,
    output logic                   fcc_rcvd,
    output logic                   null_seen,
    output logic                   par_err,
    output logic                   disc_err,
    output logic                   ovf_err,
    output logic [$clog2(DEPTH):0] fifo_level
`ifdef DS_LINK_RX_STATS_EN
    ,
    output logic [15:0]            char_count,
    output logic [7:0]             err_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int IW = $clog2(DISC_CYCLES + 1);

    typedef enum logic [2:0] {
        S_WAIT, S_PAR, S_DATA, S_CTRL, S_ERR
    } state_e;

    logic [1:0]        d_sync_q, s_sync_q;
    logic              x_q, ev_q, evb_q, x_now;
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d, sh_nx;
    logic              c0_q, c0_d, par_q, par_d, acc_q, acc_d;
    logic              chk_q, chk_d, esc_q, esc_d;
    logic [IW-1:0]     idle_q;
    logic              push_q, push_d, pctl_q, pctl_d, fcc_q, fcc_d;
    logic [DATA_W-1:0] pdat_q, pdat_d;
    logic              null_q, perr_q, derr_q, oerr_q;
    logic              null_set, perr_set, ovf_set, disc_now;
    logic [DATA_W:0]   mem_q [DEPTH];
    logic [DATA_W:0]   head;
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       lvl_q;
    logic              pop, full, wr_en;

    assign x_now = d_sync_q[1] ^ s_sync_q[1];
    assign sh_nx = {evb_q, sh_q[DATA_W-1:1]};

    // A bit event is any change of d^s between consecutive synchronised samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_sync_q <= '0;
            s_sync_q <= '0;
            x_q      <= 1'b0;
            ev_q     <= 1'b0;
            evb_q    <= 1'b0;
        end else begin
            d_sync_q <= {d_sync_q[0], d_in};
            s_sync_q <= {s_sync_q[0], s_in};
            x_q      <= x_now;
            ev_q     <= x_now ^ x_q;
            evb_q    <= d_sync_q[1];
        end
    end

    assign disc_now = (state_q != S_WAIT) && !ev_q
                   && (idle_q == IW'(DISC_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        c0_d     = c0_q;
        par_d    = par_q;
        acc_d    = acc_q;
        chk_d    = chk_q;
        esc_d    = esc_q;
        push_d   = 1'b0;
        pctl_d   = 1'b0;
        pdat_d   = '0;
        fcc_d    = 1'b0;
        null_set = 1'b0;
        perr_set = 1'b0;
        unique case (state_q)
            S_WAIT: if (ev_q) begin
                state_d = S_PAR;
                par_d   = evb_q;
                cnt_d   = CW'(1);
                chk_d   = 1'b0;
                esc_d   = 1'b0;
                acc_d   = 1'b0;
            end
            // cnt_q[0]: 0 = expecting parity bit, 1 = expecting flag bit
            S_PAR: if (ev_q) begin
                if (cnt_q == '0) begin
                    par_d = evb_q;
                    cnt_d = CW'(1);
                end else if (chk_q && !(acc_q ^ par_q ^ evb_q)) begin
                    perr_set = 1'b1;
                    state_d  = S_ERR;
                end else begin
                    state_d = evb_q ? S_CTRL : S_DATA;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                    chk_d   = 1'b1;
                end
            end
            S_DATA: if (ev_q) begin
                acc_d = acc_q ^ evb_q;
                sh_d  = sh_nx;
                if (cnt_q == CW'(DATA_W - 1)) begin
                    state_d = S_PAR;
                    cnt_d   = '0;
                    if (esc_q) begin
                        perr_set = 1'b1;
                        state_d  = S_ERR;
                    end else begin
                        push_d = 1'b1;
                        pdat_d = sh_nx;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CTRL: if (ev_q) begin
                acc_d = acc_q ^ evb_q;
                if (cnt_q == '0) begin
                    c0_d  = evb_q;
                    cnt_d = CW'(1);
                end else begin
                    state_d = S_PAR;
                    cnt_d   = '0;
                    if (esc_q) begin
                        esc_d = 1'b0;
                        if (!evb_q && !c0_q) begin
                            null_set = 1'b1;
                        end else begin
                            perr_set = 1'b1;
                            state_d  = S_ERR;
                        end
                    end else if (!evb_q && !c0_q) begin
                        fcc_d = 1'b1;
                    end else if (evb_q && c0_q) begin
                        esc_d = 1'b1;
                    end else begin
                        push_d = 1'b1;
                        pctl_d = 1'b1;
                        pdat_d = {{(DATA_W-1){1'b0}}, c0_q};
                    end
                end
            end
            S_ERR: if (err_clr && !disc_now) state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
        if (disc_now) state_d = S_ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
            sh_q    <= '0;
            c0_q    <= 1'b0;
            par_q   <= 1'b0;
            acc_q   <= 1'b0;
            chk_q   <= 1'b0;
            esc_q   <= 1'b0;
            idle_q  <= '0;
            push_q  <= 1'b0;
            pctl_q  <= 1'b0;
            pdat_q  <= '0;
            fcc_q   <= 1'b0;
            null_q  <= 1'b0;
            perr_q  <= 1'b0;
            derr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            c0_q    <= c0_d;
            par_q   <= par_d;
            acc_q   <= acc_d;
            chk_q   <= chk_d;
            esc_q   <= esc_d;
            if (state_q == S_WAIT || ev_q) idle_q <= '0;
            else if (idle_q != IW'(DISC_CYCLES)) idle_q <= idle_q + 1'b1;
            push_q  <= push_d;
            pctl_q  <= pctl_d;
            pdat_q  <= pdat_d;
            fcc_q   <= fcc_d;
            null_q  <= !disc_now && (null_q || null_set);
            perr_q  <= perr_set || (perr_q && !err_clr);
            derr_q  <= disc_now || (derr_q && !err_clr);
            oerr_q  <= ovf_set || (oerr_q && !err_clr);
        end
    end

    assign pop     = rx_valid && rx_ready;
    assign full    = lvl_q == (AW+1)'(DEPTH);
    assign wr_en   = push_q && (!full || pop) && !disc_now;
    assign ovf_set = push_q && full && !pop && !disc_now;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= {pctl_q, pdat_q};
    end

    // Disconnect flushes the FIFO and takes priority over any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else if (disc_now) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            lvl_q <= lvl_q + (AW+1)'(wr_en) - (AW+1)'(pop);
        end
    end

    assign head       = mem_q[rd_q];
    assign rx_valid   = lvl_q != '0;
    assign rx_ctrl    = rx_valid && head[DATA_W];
    assign rx_data    = rx_valid ? head[DATA_W-1:0] : '0;
    assign fifo_level = lvl_q;
    assign fcc_rcvd   = fcc_q;
    assign null_seen  = null_q;
    assign par_err    = perr_q;
    assign disc_err   = derr_q;
    assign ovf_err    = oerr_q;

`ifdef DS_LINK_RX_STATS_EN
    logic [15:0] chr_q;
    logic [7:0]  errc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chr_q  <= '0;
            errc_q <= '0;
        end else begin
            if (wr_en && !pctl_q && chr_q != '1) chr_q <= chr_q + 1'b1;
            if (state_q != S_ERR && state_d == S_ERR && errc_q != '1)
                errc_q <= errc_q + 1'b1;
        end
    end

    assign char_count = chr_q;
    assign err_count  = errc_q;
`endif
endmodule

// File: tb/tb_ds_link_rx.sv
// Randomised self-checking bench for ds_link_rx: DS line encoder, character-level
// reference model (parity rule, code table, bounded FIFO queue) and directed scenarios.
module tb_ds_link_rx;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic d_in = 1'b0, s_in = 1'b0, rx_ready = 1'b0, err_clr = 1'b0;
    logic rx_valid, rx_ctrl, fcc_rcvd, null_seen, par_err, disc_err, ovf_err;
    logic [DATA_W-1:0] rx_data;
    logic [$clog2(DEPTH):0] fifo_level;
`ifdef DS_LINK_RX_STATS_EN
    logic [15:0] char_count;
    logic [7:0]  err_count;
`endif

    ds_link_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DISC_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .s_in(s_in),
        .rx_ready(rx_ready), .err_clr(err_clr),
        .rx_valid(rx_valid), .rx_ctrl(rx_ctrl), .rx_data(rx_data),
        .fcc_rcvd(fcc_rcvd), .null_seen(null_seen), .par_err(par_err),
        .disc_err(disc_err), .ovf_err(ovf_err), .fifo_level(fifo_level)
`ifdef DS_LINK_RX_STATS_EN
        , .char_count(char_count), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int fcc_cnt = 0;
    int fcc_exp = 0;
    bit no_pop = 1'b0;
    bit rnd_rdy = 1'b0;
    bit prev_par = 1'b0;
    logic [8:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) chk("pop_extra", exp_q.size(), 1);
            else chk("pop", {rx_ctrl, rx_data}, exp_q.pop_front());
        end
        if (rst_n && fcc_rcvd) fcc_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) rx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic settle();
        repeat (8) tick();
    endtask

    // DS encoding: data carries the bit, strobe toggles when data does not.
    task automatic send_bit(input bit b);
        int per;
        if (b != d_in) d_in = b;
        else s_in = ~s_in;
        per = $urandom_range(2, 5);
        repeat (per) tick();
    endtask

    task automatic send_char(input bit ctrl, input logic [7:0] v, input bit flip);
        int n;
        bit p;
        bit x;
        n = ctrl ? 2 : 8;
        p = 1'b1 ^ prev_par ^ ctrl;
        x = 1'b0;
        send_bit(p ^ flip);
        send_bit(ctrl);
        for (int i = 0; i < n; i++) begin
            send_bit(v[i]);
            x ^= v[i];
        end
        prev_par = x;
    endtask

    task automatic push_exp(input logic [8:0] e);
        if (!no_pop || exp_q.size() < DEPTH) exp_q.push_back(e);
    endtask

    task automatic send_data(input logic [7:0] v);
        send_char(1'b0, v, 1'b0);
        push_exp({1'b0, v});
    endtask

    task automatic send_fcc();
        send_char(1'b1, 8'd0, 1'b0);
        fcc_exp++;
    endtask

    task automatic send_eop(input bit two);
        send_char(1'b1, two ? 8'd1 : 8'd2, 1'b0);
        push_exp({1'b1, 7'd0, two});
    endtask

    task automatic send_null();
        send_char(1'b1, 8'd3, 1'b0);
        send_char(1'b1, 8'd0, 1'b0);
    endtask

    task automatic hold_rdy(input bit r);
        rx_ready = r;
        no_pop = !r;
    endtask

    task automatic drain(input string tag);
        rnd_rdy = 1'b0;
        hold_rdy(1'b1);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
    endtask

    initial begin
        #1;
        chk("rst_outs", {rx_valid, rx_ctrl, rx_data, fcc_rcvd, null_seen,
                         par_err, disc_err, ovf_err, fifo_level}, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        hold_rdy(1'b1);
        send_null();
        send_data(8'hA5);
        settle();
        chk("t1_null", null_seen, 1);
        chk("t1_fcc", fcc_cnt, fcc_exp);
        chk("t1_par", par_err, 0);
        drain("t1_drain");

        hold_rdy(1'b0);
        send_fcc();
        send_eop(1'b0);
        send_eop(1'b1);
        settle();
        chk("t2_fcc", fcc_cnt, fcc_exp);
        chk("t2_lvl", fifo_level, 2);
        drain("t2_drain");

        hold_rdy(1'b0);
        for (int i = 1; i <= 9; i++) send_data(8'(i));
        settle();
        chk("t3_lvl", fifo_level, DEPTH);
        chk("t3_ovf", ovf_err, 1);
        drain("t3_drain");
        pulse_clr();
        chk("t3_ovf_clr", ovf_err, 0);

        hold_rdy(1'b1);
        rnd_rdy = 1'b1;
        for (int k = 0; k < 30; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5) send_data(8'($urandom));
            else if (r == 6) send_eop(1'b0);
            else if (r == 7) send_eop(1'b1);
            else if (r == 8) send_fcc();
            else send_null();
        end
        settle();
        drain("rnd_drain");
        chk("rnd_fcc", fcc_cnt, fcc_exp);
        chk("rnd_par", {par_err, ovf_err, disc_err}, 0);

        hold_rdy(1'b1);
        send_data(8'h11);
        send_data(8'h22);
        send_char(1'b0, 8'h33, 1'b1);
        settle();
        chk("t4_par", par_err, 1);
        chk("t4_lvl", fifo_level, 0);
        drain("t4_drain");
        pulse_clr();
        chk("t4_clr", par_err, 0);
        send_data(8'h3C);
        send_data(8'hC3);
        settle();
        drain("t4_resume");
        chk("t4_par2", par_err, 0);

        hold_rdy(1'b0);
        send_data(8'h5E);
        send_data(8'hE5);
        settle();
        chk("t5_lvl", fifo_level, 2);
        repeat (100) tick();
        chk("t5_disc", disc_err, 1);
        chk("t5_flush", {rx_valid, fifo_level}, 0);
        chk("t5_null", null_seen, 0);
        exp_q.delete();
        pulse_clr();
        chk("t5_clr", disc_err, 0);

        send_data(8'h77);
        settle();
        chk("t6_pre_lvl", fifo_level, 1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst", {rx_valid, rx_ctrl, rx_data, fcc_rcvd, null_seen,
                       par_err, disc_err, ovf_err, fifo_level}, 0);
        d_in = 1'b0;
        s_in = 1'b0;
        exp_q.delete();
        prev_par = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        hold_rdy(1'b1);
        send_char(1'b0, 8'h5A, 1'b1);
        push_exp({1'b0, 8'h5A});
        send_data(8'h96);
        settle();
        drain("t6_drain");
        chk("t6_par", par_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
